scrambler_tx: RTL and testbench

// - 64b/66b TX self-synchronising scrambler (G(x)=1+x^39+x^58), directly upstream of the TX gearbox.
// - Scrambles the 64-bit payload; the 2-bit sync header passes through unscrambled.
// - Holds its output while the gearbox stalls (accept low); inserts an idle block when upstream underflows.

---
 rtl/pcs_pkg.sv | 22 ++
 rtl/scrambler_tx_if.sv | 25 ++
 rtl/scrambler_lfsr.sv | 30 +++
 rtl/scrambler_tx.sv | 83 ++++++++
 tb/tb_scrambler_tx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS constants and types for the TX scrambler and its neighbours.
package pcs_pkg;

    localparam int DATA_W  = 64;
    localparam int HEAD_W  = 2;
    localparam int SCRAM_W = 58;

    // Feedback taps of G(x) = 1 + x^39 + x^58, counted in bits back from the current bit.
    localparam int TAP_NEAR = 39;
    localparam int TAP_FAR  = SCRAM_W;

    typedef logic [HEAD_W-1:0]  head_t;
    typedef logic [DATA_W-1:0]  block_t;
    typedef logic [SCRAM_W-1:0] scram_t;

    localparam head_t      SYNC_HEAD_DATA  = 2'b01;
    localparam head_t      SYNC_HEAD_CTRL  = 2'b10;
    localparam logic [7:0] BLOCK_TYPE_IDLE = 8'h1E;
    localparam block_t     IDLE_BLOCK      = {{(DATA_W-8){1'b0}}, BLOCK_TYPE_IDLE};
    localparam scram_t     SCRAM_SEED      = {SCRAM_W{1'b1}};

endpackage

// File: rtl/scrambler_tx_if.sv
// Block stream between the PCS encoder, the TX scrambler and the TX gearbox.
// Signal names are seen from the scrambler (slave modport).
interface scrambler_tx_if;
    import pcs_pkg::*;

    logic   valid_i;
    head_t  head_i;
    block_t data_i;
    logic   ready_o;
    logic   accept_i;
    head_t  head_o;
    block_t data_o;
    logic   underflow_o;

    modport master (
        output valid_i, head_i, data_i, accept_i,
        input  ready_o, head_o, data_o, underflow_o
    );

    modport slave (
        input  valid_i, head_i, data_i, accept_i,
        output ready_o, head_o, data_o, underflow_o
    );

endinterface

// File: rtl/scrambler_lfsr.sv
// Combinational one-block step of the self-synchronising x^58 + x^39 + 1 scrambler, LSB first.
// DESCRAMBLE=1 feeds the received bits into the history instead of the produced bits (RX use).
module scrambler_lfsr
    import pcs_pkg::*;
#(
    parameter bit DESCRAMBLE = 1'b0
) (
    input  scram_t scram_i,
    input  block_t data_i,
    output block_t data_o,
    output scram_t scram_o
);

    // hist[SCRAM_W-1:0] is the incoming state (oldest bit at index 0);
    // hist[SCRAM_W+i] is the history bit generated at position i of this block.
    always_comb begin : stepBlock
        logic [SCRAM_W+DATA_W-1:0] hist;
        block_t                    res;
        hist              = '0;
        res               = '0;
        hist[SCRAM_W-1:0] = scram_i;
        for (int i = 0; i < DATA_W; i++) begin
            res[i]            = data_i[i] ^ hist[i + SCRAM_W - TAP_NEAR] ^ hist[i + SCRAM_W - TAP_FAR];
            hist[SCRAM_W + i] = DESCRAMBLE ? data_i[i] : res[i];
        end
        data_o  = res;
        scram_o = hist[SCRAM_W+DATA_W-1 -: SCRAM_W];
    end

endmodule

// File: rtl/scrambler_tx.sv
// 64b/66b TX scrambler feeding the gearbox: scrambles the payload, passes the sync header,
// holds while the gearbox stalls and inserts idle blocks on underflow. Option: SCRAMBLER_BYPASS_EN.
module scrambler_tx
    import pcs_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic          bypass_i,
`endif
    scrambler_tx_if.slave bus
);

    head_t  head_q, head_d;
    block_t data_q, data_d;
    scram_t scram_q, scram_d;
    logic   underflow_q, underflow_d;

    head_t  headSel;
    block_t blockSel;
    block_t scrData;
    scram_t scrNext;
    logic   bypassActive;

`ifdef SCRAMBLER_BYPASS_EN
    assign bypassActive = bypass_i;
`else
    assign bypassActive = 1'b0;
`endif

    // An empty upstream is replaced by an idle control block so the line never starves.
    always_comb begin
        headSel  = SYNC_HEAD_CTRL;
        blockSel = IDLE_BLOCK;
        if (bus.valid_i) begin
            headSel  = bus.head_i;
            blockSel = bus.data_i;
        end
    end

    scrambler_lfsr #(
        .DESCRAMBLE (1'b0)
    ) u_lfsr (
        .scram_i (scram_q),
        .data_i  (blockSel),
        .data_o  (scrData),
        .scram_o (scrNext)
    );

    // The state advances on every accepted block, bypassed or not, so releasing bypass is seamless.
    always_comb begin
        head_d      = head_q;
        data_d      = data_q;
        scram_d     = scram_q;
        underflow_d = 1'b0;
        if (bus.accept_i) begin
            head_d      = headSel;
            data_d      = bypassActive ? blockSel : scrData;
            scram_d     = scrNext;
            underflow_d = ~bus.valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= SYNC_HEAD_CTRL;
            data_q      <= IDLE_BLOCK;
            scram_q     <= SCRAM_SEED;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            data_q      <= data_d;
            scram_q     <= scram_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.ready_o     = bus.accept_i;
    assign bus.head_o      = head_q;
    assign bus.data_o      = data_q;
    assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_scrambler_tx.sv
// Self-checking bench for scrambler_tx: directed vector table, reset/stall corners,
// self-sync stream into a serial reference descrambler, and bypass when SCRAMBLER_BYPASS_EN is set.
module tb_scrambler_tx;
    import pcs_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    scrambler_tx_if busIf();

`ifdef SCRAMBLER_BYPASS_EN
    logic bypassIn = 1'b0;

    scrambler_tx dut (
        .clk      (clk),
        .reset    (reset),
        .bypass_i (bypassIn),
        .bus      (busIf)
    );
`else
    scrambler_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );
`endif

    int compared   = 0;
    int mismatched = 0;

    // Serial reference: modelSt[0] is the newest scrambled bit, modelSt[57] the oldest.
    logic [57:0] modelSt;
    logic [57:0] descSt;
    logic [1:0]  expHead;
    logic [63:0] expData;
    logic        expUnder;
    logic        modelBypass = 1'b0;

    typedef struct {
        logic        valid;
        logic [1:0]  head;
        logic [63:0] data;
        logic        accept;
        logic [1:0]  expHead;
        logic        expUnder;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        modelSt  = '1;
        expHead  = 2'b10;
        expData  = 64'h1E;
        expUnder = 1'b0;
    endtask

    task automatic modelScramble(input logic [63:0] d, output logic [63:0] o);
        logic b;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            b       = d[i] ^ modelSt[38] ^ modelSt[57];
            o[i]    = b;
            modelSt = {modelSt[56:0], b};
        end
    endtask

    task automatic refDescramble(input logic [63:0] s, output logic [63:0] o);
        o = '0;
        for (int i = 0; i < 64; i++) begin
            o[i]   = s[i] ^ descSt[38] ^ descSt[57];
            descSt = {descSt[56:0], s[i]};
        end
    endtask

    task automatic predict(input logic valid, input logic [1:0] head, input logic [63:0] data, input logic accept);
        logic [63:0] d;
        logic [63:0] s;
        if (accept) begin
            expHead = valid ? head : 2'b10;
            d       = valid ? data : 64'h1E;
            modelScramble(d, s);
            expData  = modelBypass ? d : s;
            expUnder = ~valid;
        end else begin
            expUnder = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] head, input logic [63:0] data, input logic accept);
        busIf.valid_i  = valid;
        busIf.head_i   = head;
        busIf.data_i   = data;
        busIf.accept_i = accept;
        #1;
        checkOutput("readyFollowsAccept", 64'(busIf.ready_o), 64'(accept));
        predict(valid, head, data, accept);
        @(posedge clk);
        #1;
        checkOutput("headOut", 64'(busIf.head_o), 64'(expHead));
        checkOutput("dataOut", busIf.data_o, expData);
        checkOutput("underflowOut", 64'(busIf.underflow_o), 64'(expUnder));
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  h;
        logic [63:0] rec;

        vecs[0]  = '{1'b1, 2'b01, 64'h0000_0000_0000_0000, 1'b1, 2'b01, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b1, 2'b10, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b01, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 2'b10, 1'b1};
        vecs[5]  = '{1'b0, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 2'b10, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 2'b00, 1'b0};
        vecs[7]  = '{1'b1, 2'b11, 64'h8000_0000_0000_0001, 1'b0, 2'b00, 1'b0};
        vecs[8]  = '{1'b1, 2'b11, 64'h8000_0000_0000_0001, 1'b0, 2'b00, 1'b0};
        vecs[9]  = '{1'b1, 2'b11, 64'h8000_0000_0000_0001, 1'b1, 2'b11, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 64'h0000_0000_0000_0000, 1'b1, 2'b10, 1'b1};
        vecs[11] = '{1'b0, 2'b01, 64'h0000_0000_0000_0000, 1'b1, 2'b10, 1'b1};
        vecs[12] = '{1'b1, 2'b01, 64'h5555_5555_5555_5555, 1'b1, 2'b01, 1'b0};

        reset          = 1'b1;
        busIf.valid_i  = 1'b0;
        busIf.head_i   = 2'b00;
        busIf.data_i   = '0;
        busIf.accept_i = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetHead", 64'(busIf.head_o), 64'(2'b10));
        checkOutput("resetData", busIf.data_o, 64'h1E);
        checkOutput("resetUnderflow", 64'(busIf.underflow_o), 64'(1'b0));
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].head, vecs[i].data, vecs[i].accept);
            checkOutput($sformatf("vec%0dHead", i), 64'(busIf.head_o), 64'(vecs[i].expHead));
            checkOutput($sformatf("vec%0dUnderflow", i), 64'(busIf.underflow_o), 64'(vecs[i].expUnder));
            if (i == 0)
                checkOutput("firstBlockGolden", busIf.data_o, 64'h03FF_FF80_0000_0000);
        end

        $display("[TB] reset during stall");
        busIf.valid_i  = 1'b1;
        busIf.head_i   = 2'b01;
        busIf.data_i   = 64'h1234_5678_9ABC_DEF0;
        busIf.accept_i = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midResetHead", 64'(busIf.head_o), 64'(2'b10));
        checkOutput("midResetData", busIf.data_o, 64'h1E);
        checkOutput("midResetUnderflow", 64'(busIf.underflow_o), 64'(1'b0));
        reset = 1'b0;
        modelReset();
        applyStimulus(1'b1, 2'b01, 64'h0, 1'b1);
        checkOutput("reseedGolden", busIf.data_o, 64'h03FF_FF80_0000_0000);

        $display("[TB] self-sync stream");
        descSt = '0;
        for (int n = 0; n < 1000; n++) begin
            d = {$urandom, $urandom};
            h = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            if ($urandom_range(0, 32) == 0)
                applyStimulus(1'b1, h, d, 1'b0);
            applyStimulus(1'b1, h, d, 1'b1);
            refDescramble(busIf.data_o, rec);
            checkOutput("selfSyncHead", 64'(busIf.head_o), 64'(h));
            if (n >= 1)
                checkOutput("selfSyncPayload", rec, d);
        end

`ifdef SCRAMBLER_BYPASS_EN
        $display("[TB] bypass");
        bypassIn    = 1'b1;
        modelBypass = 1'b1;
        for (int n = 0; n < 3; n++) begin
            d = {$urandom, $urandom};
            applyStimulus(1'b1, 2'b01, d, 1'b1);
            checkOutput("bypassData", busIf.data_o, d);
        end
        bypassIn    = 1'b0;
        modelBypass = 1'b0;
        applyStimulus(1'b1, 2'b01, 64'hF0F0_0F0F_A5A5_5A5A, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
